// File: rtl/fifo_dual_deque_pkg.sv
// Shared defaults, per-cycle operation record and the pointer-wrap helper for fifo_dual_deque.
package fifo_dual_deque_pkg;

   localparam int unsigned DefDwidth    = 64;
   localparam int unsigned DefQueueSize = 21;

   typedef struct packed {
      logic enq;
      logic pop_a;
      logic pop_b;
   } fifo_ops_t;

   // step never exceeds 2 and size is at least 2, so one conditional subtract wraps correctly
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned step,
                                           input int unsigned size);
      int unsigned sum;
      sum = ptr + step;
      return (sum >= size) ? (sum - size) : sum;
   endfunction

endpackage

// File: rtl/fifo_dual_deque_mem.sv
// Storage for fifo_dual_deque: one synchronous write port, two combinational read ports.
module fifo_dual_deque_mem
   import fifo_dual_deque_pkg::*;
#(
   parameter int unsigned DWIDTH     = DefDwidth,
   parameter int unsigned QUEUE_SIZE = DefQueueSize,
   parameter int unsigned AWIDTH     = $clog2(DefQueueSize)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AWIDTH-1:0] wr_addr,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic [AWIDTH-1:0] rd_addr_a,
   output logic [DWIDTH-1:0] rd_data_a,
   input  logic [AWIDTH-1:0] rd_addr_b,
   output logic [DWIDTH-1:0] rd_data_b
);

   logic [DWIDTH-1:0] mem_q [QUEUE_SIZE];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = mem_q[rd_addr_a];
   assign rd_data_b = mem_q[rd_addr_b];

endmodule

// File: rtl/fifo_dual_deque.sv
// Show-ahead FIFO exposing the two oldest entries, able to pop one or two per cycle.
// Define FIFO_DUAL_DEQUE_ERR_EN to add a sticky protocol-error output 'err'.
module fifo_dual_deque
   import fifo_dual_deque_pkg::*;
#(
   parameter int unsigned DWIDTH     = DefDwidth,
   parameter int unsigned QUEUE_SIZE = DefQueueSize
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_enque_en,
   input  logic [DWIDTH-1:0] in_data,
   output logic              in_valid,
   input  logic              outA_deque_en,
   output logic              outA_valid,
   output logic [DWIDTH-1:0] outA_data,
   input  logic              outB_deque_en,
   output logic              outB_valid,
   output logic [DWIDTH-1:0] outB_data
`ifdef FIFO_DUAL_DEQUE_ERR_EN
   ,
   output logic              err
`endif
);

   localparam int unsigned PtrW = $clog2(QUEUE_SIZE);
   localparam int unsigned CntW = $clog2(QUEUE_SIZE + 1);

   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;
   logic [PtrW-1:0] head_next;
   logic [DWIDTH-1:0] rd_data_a, rd_data_b;
   fifo_ops_t       ops;
   int unsigned     pop_cnt;

   assign head_next = PtrW'(ptr_inc(32'(head_q), 32'd1, QUEUE_SIZE));

   always_comb begin
      in_valid   = !rst && (count_q < CntW'(QUEUE_SIZE));
      outA_valid = !rst && (count_q >= CntW'(1));
      outB_valid = !rst && (count_q >= CntW'(2));

      ops       = '0;
      ops.enq   = in_enque_en && in_valid;
      ops.pop_a = outA_deque_en && outA_valid;
      // B may only leave together with A, otherwise order would break
      ops.pop_b = outB_deque_en && outB_valid && ops.pop_a;

      pop_cnt = 32'(ops.pop_a) + 32'(ops.pop_b);

      tail_d = tail_q;
      if (ops.enq) begin
         tail_d = PtrW'(ptr_inc(32'(tail_q), 32'd1, QUEUE_SIZE));
      end
      head_d  = PtrW'(ptr_inc(32'(head_q), pop_cnt, QUEUE_SIZE));
      count_d = count_q + CntW'(ops.enq) - CntW'(ops.pop_a) - CntW'(ops.pop_b);

      outA_data = outA_valid ? rd_data_a : '0;
      outB_data = outB_valid ? rd_data_b : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   fifo_dual_deque_mem #(
      .DWIDTH    (DWIDTH),
      .QUEUE_SIZE(QUEUE_SIZE),
      .AWIDTH    (PtrW)
   ) u_mem (
      .clk      (clk),
      .wr_en    (ops.enq),
      .wr_addr  (tail_q),
      .wr_data  (in_data),
      .rd_addr_a(head_q),
      .rd_data_a(rd_data_a),
      .rd_addr_b(head_next),
      .rd_data_b(rd_data_b)
   );

`ifdef FIFO_DUAL_DEQUE_ERR_EN
   logic err_q, err_d;

   always_comb begin
      err_d = err_q
            | (in_enque_en && !in_valid)
            | (outA_deque_en && !outA_valid)
            | (outB_deque_en && !ops.pop_b);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

   count_in_range: assert property (@(posedge clk) disable iff (rst)
      count_q <= CntW'(QUEUE_SIZE));

endmodule

// File: tb/tb_fifo_dual_deque.sv
// Directed self-checking bench for fifo_dual_deque at DWIDTH=64, QUEUE_SIZE=21.
module tb_fifo_dual_deque;

   localparam int unsigned DW = 64;
   localparam int unsigned QS = 21;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_enque_en;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          outA_deque_en;
   logic          outA_valid;
   logic [DW-1:0] outA_data;
   logic          outB_deque_en;
   logic          outB_valid;
   logic [DW-1:0] outB_data;
`ifdef FIFO_DUAL_DEQUE_ERR_EN
   logic          err;
`endif

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_v [20];

   always #5 clk = ~clk;

   fifo_dual_deque #(
      .DWIDTH    (DW),
      .QUEUE_SIZE(QS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_enque_en  (in_enque_en),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .outA_deque_en(outA_deque_en),
      .outA_valid   (outA_valid),
      .outA_data    (outA_data),
      .outB_deque_en(outB_deque_en),
      .outB_valid   (outB_valid),
      .outB_data    (outB_data)
`ifdef FIFO_DUAL_DEQUE_ERR_EN
      ,
      .err          (err)
`endif
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp_b);
      checks++;
      assert (obs === exp_b) else begin
         errors++;
         $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp_b);
      end
   endtask

   task automatic chkd(input string tag, input logic [63:0] obs, input logic [63:0] exp_d);
      checks++;
      assert (obs === exp_d) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_d);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      in_enque_en   = 1'b0;
      in_data       = '0;
      outA_deque_en = 1'b0;
      outB_deque_en = 1'b0;
      cyc();
      cyc();
      chk1("rst_in_valid", in_valid, 1'b0);
      chk1("rst_a_valid", outA_valid, 1'b0);
      chk1("rst_b_valid", outB_valid, 1'b0);
      chkd("rst_a_data", outA_data, 64'd0);
      chkd("rst_b_data", outB_data, 64'd0);
      rst = 1'b0;
      #1;
      chk1("post_rst_in_valid", in_valid, 1'b1);
      chk1("post_rst_a_valid", outA_valid, 1'b0);
`ifdef FIFO_DUAL_DEQUE_ERR_EN
      chk1("post_rst_err", err, 1'b0);
`endif

      // Fill to capacity
      in_enque_en = 1'b1;
      for (int i = 0; i < 21; i++) begin
         in_data = 64'(114514 + i);
         cyc();
         if (i == 0) begin
            chk1("first_a_valid", outA_valid, 1'b1);
            chk1("first_b_valid", outB_valid, 1'b0);
            chkd("first_a_data", outA_data, 64'd114514);
            chkd("first_b_data", outB_data, 64'd0);
         end
         if (i == 19) chk1("fill20_in_valid", in_valid, 1'b1);
      end
      in_enque_en = 1'b0;
      chk1("full_in_valid", in_valid, 1'b0);
      chk1("full_b_valid", outB_valid, 1'b1);
      chkd("full_a_data", outA_data, 64'd114514);
      chkd("full_b_data", outB_data, 64'd114515);

      // Enqueue while full is dropped
      in_enque_en = 1'b1;
      in_data     = 64'd999;
      cyc();
      in_enque_en = 1'b0;
      chk1("ovf_in_valid", in_valid, 1'b0);
      chkd("ovf_a_data", outA_data, 64'd114514);
`ifdef FIFO_DUAL_DEQUE_ERR_EN
      chk1("ovf_err", err, 1'b1);
`endif

      // Pair drain
      outA_deque_en = 1'b1;
      outB_deque_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chk1("drain_b_valid", outB_valid, 1'b1);
         chkd("drain_a_data", outA_data, 64'(114514 + 2 * k));
         chkd("drain_b_data", outB_data, 64'(114515 + 2 * k));
         cyc();
         if (k == 0) chk1("drain_in_valid", in_valid, 1'b1);
      end
      chk1("last_a_valid", outA_valid, 1'b1);
      chk1("last_b_valid", outB_valid, 1'b0);
      chkd("last_a_data", outA_data, 64'd114534);
      chkd("last_b_data", outB_data, 64'd0);
      cyc();
      outA_deque_en = 1'b0;
      outB_deque_en = 1'b0;
      chk1("empty_a_valid", outA_valid, 1'b0);
      chkd("empty_a_data", outA_data, 64'd0);
      chk1("empty_in_valid", in_valid, 1'b1);

      // B-only request is ignored
      in_enque_en = 1'b1;
      in_data = 64'hA1; cyc();
      in_data = 64'hA2; cyc();
      in_data = 64'hA3; cyc();
      in_enque_en   = 1'b0;
      outB_deque_en = 1'b1;
      cyc();
      cyc();
      outB_deque_en = 1'b0;
      chk1("bonly_a_valid", outA_valid, 1'b1);
      chk1("bonly_b_valid", outB_valid, 1'b1);
      chkd("bonly_a_data", outA_data, 64'hA1);
      chkd("bonly_b_data", outB_data, 64'hA2);
      outA_deque_en = 1'b1;
      cyc();
      outA_deque_en = 1'b0;
      chkd("aonly_a_data", outA_data, 64'hA2);
      chkd("aonly_b_data", outB_data, 64'hA3);
      outA_deque_en = 1'b1;
      outB_deque_en = 1'b1;
      cyc();
      chk1("pair_empty_a_valid", outA_valid, 1'b0);
      cyc();  // requests on an empty queue are ignored
      outA_deque_en = 1'b0;
      outB_deque_en = 1'b0;
      in_enque_en   = 1'b1;
      in_data       = 64'h55;
      cyc();
      chkd("after_empty_req_a", outA_data, 64'h55);
      chk1("after_empty_req_bv", outB_valid, 1'b0);

      // Reset mid-operation at count 7
      for (int i = 0; i < 6; i++) begin
         in_data = 64'(8'h60 + i);
         cyc();
      end
      chk1("seven_b_valid", outB_valid, 1'b1);
      rst           = 1'b1;
      in_data       = 64'h77;
      outA_deque_en = 1'b1;
      #1;
      chk1("midrst_in_valid", in_valid, 1'b0);
      chk1("midrst_a_valid", outA_valid, 1'b0);
      chk1("midrst_b_valid", outB_valid, 1'b0);
      chkd("midrst_a_data", outA_data, 64'd0);
      chkd("midrst_b_data", outB_data, 64'd0);
      cyc();
      rst           = 1'b0;
      in_enque_en   = 1'b0;
      outA_deque_en = 1'b0;
      #1;
      chk1("midrst_after_in_valid", in_valid, 1'b1);
      chk1("midrst_after_a_valid", outA_valid, 1'b0);
      chk1("midrst_after_b_valid", outB_valid, 1'b0);
`ifdef FIFO_DUAL_DEQUE_ERR_EN
      chk1("midrst_err", err, 1'b0);
`endif

      // Wrap: 15 in, 15 out, 10 in across index 20 -> 0
      in_enque_en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         in_data = 64'(12'h100 + i);
         cyc();
      end
      in_enque_en   = 1'b0;
      outB_deque_en = 1'b1;
      cyc();
      outB_deque_en = 1'b0;
      chkd("wrap_bonly_a", outA_data, 64'h100);
`ifdef FIFO_DUAL_DEQUE_ERR_EN
      chk1("wrap_bonly_err", err, 1'b1);
`endif
      outA_deque_en = 1'b1;
      for (int i = 0; i < 15; i++) begin
         chkd("wrap_pop1", outA_data, 64'(12'h100 + i));
         cyc();
      end
      outA_deque_en = 1'b0;
      chk1("wrap_mid_empty", outA_valid, 1'b0);
      in_enque_en = 1'b1;
      for (int j = 0; j < 10; j++) begin
         in_data = 64'(12'h200 + j);
         cyc();
      end
      in_enque_en   = 1'b0;
      outA_deque_en = 1'b1;
      for (int j = 0; j < 10; j++) begin
         chkd("wrap_pop2_a", outA_data, 64'(12'h200 + j));
         if (j < 9) chkd("wrap_pop2_b", outB_data, 64'(12'h201 + j));
         else chk1("wrap_pop2_bv", outB_valid, 1'b0);
         cyc();
      end
      outA_deque_en = 1'b0;
      chk1("wrap_end_empty", outA_valid, 1'b0);

      // Simultaneous enqueue and dequeue
      in_enque_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_data = 64'(12'h300 + i);
         cyc();
      end
      in_data       = 64'h3FF;
      outA_deque_en = 1'b1;
      outB_deque_en = 1'b1;
      #1;
      chk1("sim20_in_valid", in_valid, 1'b1);
      chkd("sim20_a", outA_data, 64'h300);
      chkd("sim20_b", outB_data, 64'h301);
      cyc();
      outA_deque_en = 1'b0;
      outB_deque_en = 1'b0;
      in_data       = 64'h3A0;
      chk1("sim19_in_valid", in_valid, 1'b1);
      chkd("sim19_a", outA_data, 64'h302);
      cyc();
      in_data = 64'h3A1;
      chk1("sim20b_in_valid", in_valid, 1'b1);
      cyc();
      chk1("sim21_in_valid", in_valid, 1'b0);
      in_data       = 64'hBAD;
      outA_deque_en = 1'b1;
      cyc();
      in_enque_en   = 1'b0;
      outA_deque_en = 1'b0;
      chk1("simfull_in_valid", in_valid, 1'b1);
      chkd("simfull_a", outA_data, 64'h303);
`ifdef FIFO_DUAL_DEQUE_ERR_EN
      chk1("simfull_err", err, 1'b1);
`endif
      for (int i = 0; i < 17; i++) exp_v[i] = 64'(12'h303 + i);
      exp_v[17] = 64'h3FF;
      exp_v[18] = 64'h3A0;
      exp_v[19] = 64'h3A1;
      outA_deque_en = 1'b1;
      outB_deque_en = 1'b1;
      for (int k = 0; k < 10; k++) begin
         chkd("final_a", outA_data, exp_v[2 * k]);
         chkd("final_b", outB_data, exp_v[2 * k + 1]);
         cyc();
      end
      outA_deque_en = 1'b0;
      outB_deque_en = 1'b0;
      chk1("final_empty", outA_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
